// File: rtl/regfile_scoreboard_if.sv
// Bundle between write-back/decode and the register file scoreboard.
// master: pipeline side (drives write/read/issue); slave: register file.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 64
);
  logic [4:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [4:0]        ReadReg1;
  logic [4:0]        ReadReg2;
  logic              Use1;
  logic              Use2;
  logic              IssueValid;
  logic              IssueWrites;
  logic [4:0]        IssueReg;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Stall;
  logic [31:0]       Busy;

  modport master (
    output WriteReg, WriteData, RegWrite,
    output ReadReg1, ReadReg2, Use1, Use2,
    output IssueValid, IssueWrites, IssueReg,
    input  ReadData1, ReadData2, Stall, Busy
  );

  modport slave (
    input  WriteReg, WriteData, RegWrite,
    input  ReadReg1, ReadReg2, Use1, Use2,
    input  IssueValid, IssueWrites, IssueReg,
    output ReadData1, ReadData2, Stall, Busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// 32 x DATA_W register file (X31 = 0) with per-register in-flight scoreboard.
// Ports: clk, reset (sync, active-high), rf (slave bundle: write-back write,
// two decode reads, issue request, Stall/Busy). Macro REGFILE_BYPASS_EN
// enables write-through forwarding and same-cycle stall release.
module regfile_scoreboard #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 2
) (
  input logic clk,
  input logic reset,
  regfile_scoreboard_if.slave rf
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [32];
  logic [CNT_W-1:0]  cnt  [32];

  logic [31:0]       inc;
  logic [31:0]       dec;
  logic [31:0]       busy;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              res1;
  logic              res2;
  logic              haz1;
  logic              haz2;
  logic              full;
  logic              stall;

  always_comb begin
    rd1 = (rf.ReadReg1 == 5'd31) ? '0 : regs[rf.ReadReg1];
    rd2 = (rf.ReadReg2 == 5'd31) ? '0 : regs[rf.ReadReg2];
    res1 = 1'b0;
    res2 = 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (rf.RegWrite && rf.WriteReg == rf.ReadReg1 &&
        rf.WriteReg != 5'd31)
      rd1 = rf.WriteData;
    if (rf.RegWrite && rf.WriteReg == rf.ReadReg2 &&
        rf.WriteReg != 5'd31)
      rd2 = rf.WriteData;
    // Last outstanding write lands this cycle: reader may proceed.
    res1 = rf.RegWrite && rf.WriteReg == rf.ReadReg1 &&
           cnt[rf.ReadReg1] == CONE;
    res2 = rf.RegWrite && rf.WriteReg == rf.ReadReg2 &&
           cnt[rf.ReadReg2] == CONE;
`endif
  end

  always_comb begin
    haz1 = rf.Use1 && rf.ReadReg1 != 5'd31 &&
           cnt[rf.ReadReg1] != '0 && !res1;
    haz2 = rf.Use2 && rf.ReadReg2 != 5'd31 &&
           cnt[rf.ReadReg2] != '0 && !res2;
    full = rf.IssueValid && rf.IssueWrites &&
           rf.IssueReg != 5'd31 && cnt[rf.IssueReg] == CMAX;
    stall = haz1 || haz2 || full;
  end

  always_comb begin
    inc  = '0;
    dec  = '0;
    busy = '0;
    for (int i = 0; i < 31; i++) begin
      inc[i]  = rf.IssueValid && !stall && rf.IssueWrites &&
                rf.IssueReg == 5'(i);
      dec[i]  = rf.RegWrite && rf.WriteReg == 5'(i) &&
                cnt[i] != '0;
      busy[i] = cnt[i] != '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (rf.RegWrite && rf.WriteReg != 5'd31)
        regs[rf.WriteReg] <= rf.WriteData;
      for (int i = 0; i < 31; i++) begin
        if (inc[i] && !dec[i])
          cnt[i] <= cnt[i] + CONE;
        else if (dec[i] && !inc[i])
          cnt[i] <= cnt[i] - CONE;
      end
    end
  end

  assign rf.ReadData1 = rd1;
  assign rf.ReadData2 = rd2;
  assign rf.Stall     = stall;
  assign rf.Busy      = busy;

endmodule
